// File: rtl/clk_div_multi.sv
// clk_div_multi -- multi-channel runtime-programmable clock divider / tick generator.
//
// Each channel counts 0..P and then wraps. At the wrap it toggles its square-wave
// output and raises a one-cycle tick. A config write lands in a shadow register.
// The shadow is copied into P only at the next wrap, so a half-period is never
// truncated or stretched.
//
// Optional build macro: SYNC_CLR_EN
//   When defined, this adds input sync_clr. A one-cycle pulse realigns every channel
//   to cnt=0 and clk_out=1. It does not touch the active period, the shadow register
//   or the pending flag.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            per-channel run enable
//   cfg_we        config write strobe
//   cfg_sel       channel addressed by the write (out-of-range values are ignored)
//   cfg_data      new terminal count
//   sync_clr      (SYNC_CLR_EN only) synchronous phase realign
//   clk_out       divided square wave per channel
//   tick          one-cycle strobe per channel on each terminal count
//   cfg_pending   written value waiting for the next boundary

module clk_div_multi_ch #(
  parameter int               WIDTH       = 25,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);
  logic [WIDTH-1:0] r_cnt, r_per, r_shd;
  logic             r_clk, r_tick, r_pend;
  logic             w_tc;

  // A realign pulse suppresses the boundary. Any pending load then waits for the
  // first real terminal count after the realign.
  assign w_tc = i_en & ~i_clr & (r_cnt == r_per);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_clk  <= 1'b1;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_clk  <= 1'b1;
      r_tick <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_clk  <= ~r_clk;
      r_tick <= 1'b1;
    end else begin
      if (i_en) r_cnt <= r_cnt + WIDTH'(1);
      r_tick <= 1'b0;
    end
  end

  // A write that coincides with the boundary goes straight into P. Otherwise it
  // parks in the shadow register until the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per  <= DEFAULT_DIV;
      r_shd  <= DEFAULT_DIV;
      r_pend <= 1'b0;
    end else if (i_wr) begin
      r_shd <= i_data;
      if (w_tc) begin
        r_per  <= i_data;
        r_pend <= 1'b0;
      end else begin
        r_pend <= 1'b1;
      end
    end else if (w_tc && r_pend) begin
      r_per  <= r_shd;
      r_pend <= 1'b0;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;
endmodule

module clk_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 25,
  parameter int DEFAULT_DIV = 24999999,
  parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [WIDTH-1:0]    cfg_data,
`ifdef SYNC_CLR_EN
  input  logic                sync_clr,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] cfg_pending
);
  localparam logic [WIDTH-1:0] LP_DEF = WIDTH'(DEFAULT_DIV);

  logic [CHANNELS-1:0] w_wr;
  logic                w_clr;

`ifdef SYNC_CLR_EN
  assign w_clr = sync_clr;
`else
  assign w_clr = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // A cfg_sel value of CHANNELS or above matches no channel, so the write is dropped.
    assign w_wr[i] = cfg_we & (cfg_sel == SEL_W'(i));

    clk_div_multi_ch #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (LP_DEF)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en[i]),
      .i_wr   (w_wr[i]),
      .i_data (cfg_data),
      .i_clr  (w_clr),
      .o_clk  (clk_out[i]),
      .o_tick (tick[i]),
      .o_pend (cfg_pending[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_data = '0;
  logic       sync_clr = 1'b0;
  logic [3:0] clk_out, tick, cfg_pending;

  // Three-channel instance: cfg_sel=3 is out of range here.
  logic [2:0] en3 = '0;
  logic       we3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic [7:0] data3 = '0;
  logic [2:0] clk3, tick3, pend3;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_multi #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DIV(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
`ifdef SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  clk_div_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .cfg_we(we3), .cfg_sel(sel3),
    .cfg_data(data3),
`ifdef SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .clk_out(clk3), .tick(tick3), .cfg_pending(pend3)
  );

  typedef struct packed {
    logic [3:0] en;
    logic       we;
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] clk_o;
    logic [3:0] tick;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic [3:0] e, input logic w, input logic [1:0] s,
                              input logic [7:0] d, input logic [3:0] c,
                              input logic [3:0] t, input logic [3:0] p);
    vec_t v;
    v.en = e; v.we = w; v.sel = s; v.data = d; v.clk_o = c; v.tick = t; v.pend = p;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // edge by edge after reset release; P=3 everywhere until written
    vecs[0]  = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    vecs[1]  = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    vecs[2]  = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    vecs[3]  = mk(4'hF, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[4]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[5]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[6]  = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[7]  = mk(4'hF, 0, 0, 0, 4'hF, 4'hF, 4'h0);
    // ch1 <- 1 mid half-period: pending until the boundary, then 2-cycle halves
    vecs[8]  = mk(4'hF, 1, 1, 1, 4'hF, 4'h0, 4'h2);
    vecs[9]  = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h2);
    vecs[10] = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h2);
    vecs[11] = mk(4'hF, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    vecs[12] = mk(4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    vecs[13] = mk(4'hF, 0, 0, 0, 4'h2, 4'h2, 4'h0);
    vecs[14] = mk(4'hF, 0, 0, 0, 4'h2, 4'h0, 4'h0);
    vecs[15] = mk(4'hF, 0, 0, 0, 4'hD, 4'hF, 4'h0);
    vecs[16] = mk(4'hF, 0, 0, 0, 4'hD, 4'h0, 4'h0);
    vecs[17] = mk(4'hF, 0, 0, 0, 4'hF, 4'h2, 4'h0);
    vecs[18] = mk(4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    // ch2 <- 0 on its terminal count: direct load, never pending, tick stuck high
    vecs[19] = mk(4'hF, 1, 2, 0, 4'h0, 4'hF, 4'h0);
    vecs[20] = mk(4'hF, 0, 0, 0, 4'h4, 4'h4, 4'h0);
    vecs[21] = mk(4'hF, 0, 0, 0, 4'h2, 4'h6, 4'h0);
    vecs[22] = mk(4'hF, 0, 0, 0, 4'h6, 4'h4, 4'h0);
    vecs[23] = mk(4'hF, 0, 0, 0, 4'h9, 4'hF, 4'h0);

    #12;
    chk("reset clk_out", clk_out, 4'hF);
    chk("reset tick", tick, 4'h0);
    chk("reset pending", cfg_pending, 4'h0);
    chk("reset3 clk_out", clk3, 3'h7);

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      en = vecs[i].en; cfg_we = vecs[i].we; cfg_sel = vecs[i].sel; cfg_data = vecs[i].data;
      en3 = vecs[i].en[2:0]; we3 = (i == 0 || i == 2); sel3 = 2'd3; data3 = 8'd0;
      step();
      chk($sformatf("vec%0d clk_out", i), clk_out, vecs[i].clk_o);
      chk($sformatf("vec%0d tick", i), tick, vecs[i].tick);
      chk($sformatf("vec%0d pending", i), cfg_pending, vecs[i].pend);
      if (i < 8) begin
        chk($sformatf("oor%0d clk_out", i), clk3, vecs[i].clk_o[2:0]);
        chk($sformatf("oor%0d tick", i), tick3, vecs[i].tick[2:0]);
        chk($sformatf("oor%0d pending", i), pend3, vecs[i].pend[2:0]);
      end
    end
    cfg_we = 1'b0; we3 = 1'b0;

    // ch0 disable at cnt=2 for 10 cycles, then resume
    en = 4'hF;
    step(); chk("en cnt1 clk0", clk_out[0], 1'b1);
    step(); chk("en cnt2 clk0", clk_out[0], 1'b1);
    en = 4'hE;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold%0d clk0", i), clk_out[0], 1'b1);
      chk($sformatf("hold%0d tick0", i), tick[0], 1'b0);
    end
    en = 4'hF;
    step(); chk("resume1 clk0", clk_out[0], 1'b1);
    chk("resume1 tick0", tick[0], 1'b0);
    step(); chk("resume2 clk0", clk_out[0], 1'b0);
    chk("resume2 tick0", tick[0], 1'b1);

    // ch3 write away from its boundary, then async reset mid-cycle
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 8'd5;
    step();
    cfg_we = 1'b0;
    chk("ch3 pending", cfg_pending, 4'h8);
    chk("pre-reset clk0", clk_out[0], 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("async clk_out", clk_out, 4'hF);
    chk("async tick", tick, 4'h0);
    chk("async pending", cfg_pending, 4'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("realign%0d clk_out", i), clk_out, 4'hF);
      chk($sformatf("realign%0d tick", i), tick, 4'h0);
    end
    step();
    chk("realign edge clk_out", clk_out, 4'h0);
    chk("realign edge tick", tick, 4'hF);

`ifdef SYNC_CLR_EN
    step();
    sync_clr = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 8'd7;
    step();
    sync_clr = 1'b0; cfg_we = 1'b0;
    chk("sclr clk_out", clk_out, 4'hF);
    chk("sclr tick", tick, 4'h0);
    chk("sclr pending", cfg_pending, 4'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sclr%0d clk_out", i), clk_out, 4'hF);
    end
    step();
    chk("sclr edge clk_out", clk_out, 4'h0);
    chk("sclr edge tick", tick, 4'hF);
    chk("sclr edge pending", cfg_pending, 4'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
